// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder (plus gate cells _xor2, _and2, _or2)          |
// | Description : LSB-first bit-serial adder. One full-adder cell and one     |
// |               carry flip-flop; the result is held until the next start.   |
// |               Define SERIAL_ADD_OVF_EN to add the signed-overflow output. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+

module _xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module _and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module _or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_p;
    logic             w_s;
    logic             w_g;
    logic             w_t;
    logic             w_cn;
    logic             w_last;
    logic             w_load;

    // Full-adder cell: sum and carry from the current LSBs and the carry FF
    _xor2 u_xor_p (.a(r_a[0]), .b(r_b[0]), .y(w_p));
    _xor2 u_xor_s (.a(w_p),    .b(r_c),    .y(w_s));
    _and2 u_and_g (.a(r_a[0]), .b(r_b[0]), .y(w_g));
    _and2 u_and_t (.a(r_c),    .b(w_p),    .y(w_t));
    _or2  u_or_c  (.a(w_g),    .b(w_t),    .y(w_cn));

    assign w_last = (r_cnt == c_last_cnt);
    assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_n = S_ADD;
            S_ADD:   if (w_last) w_state_n = S_DONE;
            S_DONE:  w_state_n = start ? S_ADD : S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= (w_state_n == S_ADD);
            r_done  <= (w_state_n == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_s   <= '0;
            r_c   <= cin;
            r_cnt <= '0;
        end else if (r_state == S_ADD) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_s   <= {w_s, r_s[WIDTH-1:1]};
            r_c   <= w_cn;
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic w_ovf_bit;
    logic r_ovf;

    // Carry into the MSB differs from carry out of it on signed overflow
    _xor2 u_xor_ovf (.a(r_c), .b(w_cn), .y(w_ovf_bit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_ADD) && w_last) begin
            r_ovf <= w_ovf_bit;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_s;
    assign cout = r_c;

endmodule
`default_nettype wire
